// File: rtl/br_flow_xbar_dest_decode.sv
// Address-to-destination decode ahead of one crossbar push flow.
// Registered 2-entry skid buffer plus saturating unmapped-address counter.
module br_flow_xbar_dest_decode #(
    parameter int Width         = 1,
    parameter int AddrWidth     = 32,
    parameter int NumPopFlows   = 2,
    parameter int NumRegions    = 4,
    parameter int DefaultDestId = 0,
    parameter int ErrCountWidth = 8,
    localparam int DestIdWidth  = $clog2(NumPopFlows)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    output logic                                      push_ready,
    input  logic                                      push_valid,
    input  logic [Width-1:0]                          push_data,
    input  logic [AddrWidth-1:0]                      push_addr,
    input  logic [NumRegions-1:0]                     cfg_region_enable,
    input  logic [NumRegions-1:0][AddrWidth-1:0]      cfg_region_base,
    input  logic [NumRegions-1:0][AddrWidth-1:0]      cfg_region_mask,
    input  logic [NumRegions-1:0][DestIdWidth-1:0]    cfg_region_dest_id,
    input  logic                                      err_count_clear,
    input  logic                                      pop_ready,
    output logic                                      pop_valid,
    output logic [Width-1:0]                          pop_data,
    output logic [DestIdWidth-1:0]                    pop_dest_id,
    output logic                                      pop_decode_error,
    output logic [ErrCountWidth-1:0]                  err_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t                 state;
    logic                   ready_q;
    logic [Width-1:0]       skid_data;
    logic [DestIdWidth-1:0] skid_dest_id;
    logic                   skid_error;
    logic [DestIdWidth-1:0] dec_dest_id;
    logic                   dec_error;
    logic                   push_fire;
    logic                   pop_fire;

    // Ready is a flop; reset only masks it so it is high right after release.
    assign push_ready = ready_q & ~rst;
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_valid & pop_ready;

    // Region decode: walk downward so the lowest-index hit is the last write.
    always_comb begin
        dec_dest_id = DestIdWidth'(DefaultDestId);
        dec_error   = 1'b1;
        for (int r = NumRegions - 1; r >= 0; r--) begin
            if (cfg_region_enable[r] &&
                ((push_addr & cfg_region_mask[r]) ==
                 (cfg_region_base[r] & cfg_region_mask[r]))) begin
                dec_dest_id = cfg_region_dest_id[r];
                dec_error   = 1'b0;
            end
        end
    end

    // Skid buffer FSM; pop side always reads from the main register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= EMPTY;
            ready_q          <= 1'b1;
            pop_valid        <= 1'b0;
            pop_data         <= '0;
            pop_dest_id      <= '0;
            pop_decode_error <= 1'b0;
            skid_data        <= '0;
            skid_dest_id     <= '0;
            skid_error       <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push_fire) begin
                        pop_data         <= push_data;
                        pop_dest_id      <= dec_dest_id;
                        pop_decode_error <= dec_error;
                        pop_valid        <= 1'b1;
                        state            <= ONE;
                    end
                end
                ONE: begin
                    if (push_fire && pop_fire) begin
                        pop_data         <= push_data;
                        pop_dest_id      <= dec_dest_id;
                        pop_decode_error <= dec_error;
                    end else if (push_fire) begin
                        skid_data    <= push_data;
                        skid_dest_id <= dec_dest_id;
                        skid_error   <= dec_error;
                        ready_q      <= 1'b0;
                        state        <= TWO;
                    end else if (pop_fire) begin
                        pop_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop_fire) begin
                        pop_data         <= skid_data;
                        pop_dest_id      <= skid_dest_id;
                        pop_decode_error <= skid_error;
                        ready_q          <= 1'b1;
                        state            <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Saturating unmapped-transfer count; clear drops a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_count_clear) begin
            err_count <= '0;
        end else if (push_fire && dec_error && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk)
        (Width >= 1) && (AddrWidth >= 1) && (NumPopFlows >= 2) &&
        (NumRegions >= 1) && (ErrCountWidth >= 1) &&
        (DefaultDestId >= 0) && (DefaultDestId < NumPopFlows));

    for (genvar r = 0; r < NumRegions; r++) begin : g_dest_chk
        a_dest_legal: assert property (@(posedge clk) disable iff (rst)
            cfg_region_enable[r] |->
                (int'(cfg_region_dest_id[r]) < NumPopFlows));
    end

    a_cfg_stable: assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=>
            ($stable(cfg_region_enable) && $stable(cfg_region_base) &&
             $stable(cfg_region_mask) && $stable(cfg_region_dest_id)));

    a_push_hold: assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=>
            (push_valid && $stable(push_data) && $stable(push_addr)));

    a_pop_hold: assert property (@(posedge clk) disable iff (rst)
        (pop_valid && !pop_ready) |=>
            (pop_valid && $stable(pop_data) && $stable(pop_dest_id) &&
             $stable(pop_decode_error)));
`endif

endmodule

// File: tb/tb_br_flow_xbar_dest_decode.sv
// Directed bench for br_flow_xbar_dest_decode: decode table vectors,
// counter saturation/clear, backpressure, streaming and mid-run reset.
module tb_br_flow_xbar_dest_decode;

    localparam int W   = 8;
    localparam int AW  = 16;
    localparam int NPF = 4;
    localparam int NR  = 4;
    localparam int EW  = 2;
    localparam int DW  = $clog2(NPF);

    logic                         clk;
    logic                         rst;
    logic                         push_ready;
    logic                         push_valid;
    logic [W-1:0]                 push_data;
    logic [AW-1:0]                push_addr;
    logic [NR-1:0]                cfg_region_enable;
    logic [NR-1:0][AW-1:0]        cfg_region_base;
    logic [NR-1:0][AW-1:0]        cfg_region_mask;
    logic [NR-1:0][DW-1:0]        cfg_region_dest_id;
    logic                         err_count_clear;
    logic                         pop_ready;
    logic                         pop_valid;
    logic [W-1:0]                 pop_data;
    logic [DW-1:0]                pop_dest_id;
    logic                         pop_decode_error;
    logic [EW-1:0]                err_count;

    int n_total;
    int n_pass;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [DW-1:0] dest;
        logic          err;
        logic [EW-1:0] cnt;
    } vec_t;

    vec_t vecs[6];

    br_flow_xbar_dest_decode #(
        .Width         (W),
        .AddrWidth     (AW),
        .NumPopFlows   (NPF),
        .NumRegions    (NR),
        .DefaultDestId (0),
        .ErrCountWidth (EW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .push_ready         (push_ready),
        .push_valid         (push_valid),
        .push_data          (push_data),
        .push_addr          (push_addr),
        .cfg_region_enable  (cfg_region_enable),
        .cfg_region_base    (cfg_region_base),
        .cfg_region_mask    (cfg_region_mask),
        .cfg_region_dest_id (cfg_region_dest_id),
        .err_count_clear    (err_count_clear),
        .pop_ready          (pop_ready),
        .pop_valid          (pop_valid),
        .pop_data           (pop_data),
        .pop_dest_id        (pop_dest_id),
        .pop_decode_error   (pop_decode_error),
        .err_count          (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_table_cfg();
        cfg_region_enable     = 4'b0111;
        cfg_region_base[0]    = 16'h1000;
        cfg_region_mask[0]    = 16'hF000;
        cfg_region_dest_id[0] = 2'd1;
        cfg_region_base[1]    = 16'h2000;
        cfg_region_mask[1]    = 16'hFF00;
        cfg_region_dest_id[1] = 2'd3;
        cfg_region_base[2]    = 16'h2000;
        cfg_region_mask[2]    = 16'hF000;
        cfg_region_dest_id[2] = 2'd2;
        cfg_region_base[3]    = 16'h4000;
        cfg_region_mask[3]    = 16'hF000;
        cfg_region_dest_id[3] = 2'd3;
    endtask

    initial begin
        int bad_rdy;
        int bad_dat;
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{addr: 16'h1234, data: 8'h5A, dest: 2'd1, err: 1'b0, cnt: 2'd0};
        vecs[1] = '{addr: 16'h20AB, data: 8'hC3, dest: 2'd3, err: 1'b0, cnt: 2'd0};
        vecs[2] = '{addr: 16'h2100, data: 8'h11, dest: 2'd2, err: 1'b0, cnt: 2'd0};
        vecs[3] = '{addr: 16'h4000, data: 8'h22, dest: 2'd0, err: 1'b1, cnt: 2'd1};
        vecs[4] = '{addr: 16'h0000, data: 8'h33, dest: 2'd0, err: 1'b1, cnt: 2'd2};
        vecs[5] = '{addr: 16'h1FFF, data: 8'hEE, dest: 2'd1, err: 1'b0, cnt: 2'd2};

        rst             = 1'b1;
        push_valid      = 1'b0;
        push_data       = '0;
        push_addr       = '0;
        err_count_clear = 1'b0;
        pop_ready       = 1'b0;
        set_table_cfg();

        #3;
        chk("rst_push_ready", 32'(push_ready), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_dec_err", 32'(pop_decode_error), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_push_ready", 32'(push_ready), 32'd1);

        pop_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_addr  = vecs[i].addr;
            push_data  = vecs[i].data;
            step();
            push_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(pop_valid), 32'd1);
            chk($sformatf("v%0d_data", i), 32'(pop_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_dest", i), 32'(pop_dest_id), 32'(vecs[i].dest));
            chk($sformatf("v%0d_err", i), 32'(pop_decode_error), 32'(vecs[i].err));
            chk($sformatf("v%0d_cnt", i), 32'(err_count), 32'(vecs[i].cnt));
            step();
            chk($sformatf("v%0d_drained", i), 32'(pop_valid), 32'd0);
        end

        push_valid = 1'b1;
        push_addr  = 16'h0000;
        push_data  = 8'h44;
        step();
        chk("sat_cnt_first", 32'(err_count), 32'd3);
        step();
        step();
        chk("sat_cnt_held", 32'(err_count), 32'd3);
        err_count_clear = 1'b1;
        step();
        err_count_clear = 1'b0;
        push_valid      = 1'b0;
        chk("clr_with_miss", 32'(err_count), 32'd0);
        chk("clr_miss_err", 32'(pop_decode_error), 32'd1);
        step();

        cfg_region_enable     = 4'b0101;
        cfg_region_base[0]    = 16'h2000;
        cfg_region_mask[0]    = 16'hF000;
        cfg_region_dest_id[0] = 2'd0;
        cfg_region_base[2]    = 16'h2000;
        cfg_region_mask[2]    = 16'hF000;
        cfg_region_dest_id[2] = 2'd1;
        push_valid = 1'b1;
        push_addr  = 16'h2000;
        push_data  = 8'h55;
        step();
        push_valid = 1'b0;
        chk("prio_both", 32'(pop_dest_id), 32'd0);
        chk("prio_both_err", 32'(pop_decode_error), 32'd0);
        step();
        cfg_region_enable = 4'b0100;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        chk("prio_r2", 32'(pop_dest_id), 32'd1);
        step();
        set_table_cfg();

        pop_ready  = 1'b0;
        push_valid = 1'b1;
        push_addr  = 16'h1000;
        push_data  = 8'hA1;
        step();
        chk("bp_ready_one", 32'(push_ready), 32'd1);
        push_data = 8'hA2;
        step();
        chk("bp_ready_two", 32'(push_ready), 32'd0);
        push_data = 8'hA3;
        step();
        chk("bp_still_full", 32'(push_ready), 32'd0);
        chk("bp_head_held", 32'(pop_data), 32'hA1);
        pop_ready = 1'b1;
        step();
        chk("bp_pop2_valid", 32'(pop_valid), 32'd1);
        chk("bp_pop2_data", 32'(pop_data), 32'hA2);
        step();
        push_valid = 1'b0;
        chk("bp_pop3_valid", 32'(pop_valid), 32'd1);
        chk("bp_pop3_data", 32'(pop_data), 32'hA3);
        step();
        chk("bp_empty", 32'(pop_valid), 32'd0);

        bad_rdy = 0;
        bad_dat = 0;
        for (int i = 0; i < 100; i++) begin
            push_valid = 1'b1;
            push_addr  = 16'h1000 | 16'(i);
            push_data  = 8'(i);
            if (push_ready !== 1'b1) bad_rdy++;
            step();
            if (pop_valid !== 1'b1 || pop_data !== 8'(i) ||
                pop_dest_id !== 2'd1) bad_dat++;
        end
        push_valid = 1'b0;
        chk("stream_ready_drops", 32'(bad_rdy), 32'd0);
        chk("stream_data_errs", 32'(bad_dat), 32'd0);
        step();
        chk("stream_drained", 32'(pop_valid), 32'd0);

        pop_ready  = 1'b0;
        push_valid = 1'b1;
        push_data  = 8'hB1;
        step();
        push_data = 8'hB2;
        step();
        push_valid = 1'b0;
        chk("mr_full", 32'(push_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_pop_valid", 32'(pop_valid), 32'd0);
        chk("mr_push_ready", 32'(push_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mr_rel_ready", 32'(push_ready), 32'd1);
        chk("mr_rel_valid", 32'(pop_valid), 32'd0);
        pop_ready = 1'b1;
        step();
        chk("mr_no_stale", 32'(pop_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
